i2c_responder: RTL and testbench

- I2C target (responder) running entirely on the fast system clock Clk; it oversamples the bus lines Scl and SdaIn.
- It is the far end of the bus whose SCL our clock divider produces for the master side: 100 kHz SCL with a 100 MHz Clk (1000 Clk per SCL period).
- It detects START, repeated START and STOP, matches a 7-bit address, ACKs, and streams bytes to and from a local byte interface.
- It drives SDA open-drain only, through SdaOe.

---
 rtl/i2c_responder_pkg.sv | 26 ++
 rtl/i2c_responder_if.sv | 32 +++
 rtl/i2c_line_filter.sv | 47 ++++
 rtl/i2c_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_responder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_responder_pkg.sv
// ============================================================================
// i2c_responder_pkg: shared widths, state encoding and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_responder_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 7;

  localparam logic [ADDR_W-1:0] GENERAL_CALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WRITE    = 3'd3,
    WR_ACK   = 3'd4,
    READ     = 3'd5,
    RD_ACK   = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_responder_if.sv
// ============================================================================
// i2c_responder_if: I2C pad lines plus the local byte stream interface
// Rev 1.0
// ============================================================================
`default_nettype none

interface i2c_responder_if;
  import i2c_responder_pkg::*;

  logic              Scl;
  logic              SdaIn;
  logic              SdaOe;
  logic [BYTE_W-1:0] RxData;
  logic              RxValid;
  logic              RxFirst;
  logic              TxReq;
  logic [BYTE_W-1:0] TxData;
  logic              Busy;

  modport slave (
    input  Scl, SdaIn, TxData,
    output SdaOe, RxData, RxValid, RxFirst, TxReq, Busy
  );

  modport master (
    output Scl, SdaIn, TxData,
    input  SdaOe, RxData, RxValid, RxFirst, TxReq, Busy
  );

endinterface

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================================
// i2c_line_filter: 2-flop synchronizer plus FILT_LEN-sample glitch filter
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic line_in,
  output logic line_f
);

  logic [1:0] sync_q, sync_d;
  logic [3:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;

  // cnt_q counts consecutive synchronized samples that disagree with the output
  always_comb begin
    sync_d = {sync_q[0], line_in};
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == 4'(FILT_LEN - 1)) filt_d = sync_q[1];
      else                           cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_f = filt_q;

endmodule

`default_nettype wire

// File: rtl/i2c_responder.sv
// ============================================================================
// i2c_responder: oversampling I2C target; GENERAL_CALL_EN also accepts 7'h00 W
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_responder
  import i2c_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h42,
  parameter int                FILT_LEN = 4,
  parameter int                HOLD_CYC = 30
) (
  input  logic            Clk,
  input  logic            Reset,
  i2c_responder_if.slave  bus
);

  logic scl_f, sda_f;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic rw_q, rw_d, first_q, first_d, sda_oe_q, sda_oe_d;
  logic rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
  logic tx_req_q, tx_req_d, tx_load_q, tx_load_d, busy_q, busy_d;
  logic hold_pend_q, hold_pend_d, hold_val_q, hold_val_d;
  logic scl_prev_q, sda_prev_q;
  logic sched, sched_val, addr_hit;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .Clk(Clk), .Reset(Reset), .line_in(bus.Scl), .line_f(scl_f)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .Clk(Clk), .Reset(Reset), .line_in(bus.SdaIn), .line_f(sda_f)
  );

  assign scl_rise  =  scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f &  scl_prev_q;
  assign start_det =  scl_f &  sda_prev_q & ~sda_f;
  assign stop_det  =  scl_f & ~sda_prev_q &  sda_f;

  // shift_q[6:0] holds the seven address bits when the R/W bit is on SDA
  always_comb begin
    addr_hit = (shift_q[ADDR_W-1:0] == DEV_ADDR);
`ifdef GENERAL_CALL_EN
    if ((shift_q[ADDR_W-1:0] == GENERAL_CALL_ADDR) && !sda_f) addr_hit = 1'b1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    hold_cnt_d  = hold_cnt_q;
    rw_d        = rw_q;
    first_d     = first_q;
    sda_oe_d    = sda_oe_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    tx_req_d    = 1'b0;
    tx_load_d   = tx_req_q;
    busy_d      = busy_q;
    hold_pend_d = hold_pend_q;
    hold_val_d  = hold_val_q;
    sched       = 1'b0;
    sched_val   = 1'b0;

    if (hold_pend_q) begin
      if (hold_cnt_q == 8'd0) begin
        sda_oe_d    = hold_val_q;
        hold_pend_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q - 8'd1;
      end
    end

    if (tx_load_q) shift_d = bus.TxData;

    case (state_q)
      IDLE: ;
      ADDR: if (scl_rise) begin
        shift_d   = {shift_q[BYTE_W-2:0], sda_f};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (addr_hit) begin
            state_d = ADDR_ACK;
            busy_d  = 1'b1;
            rw_d    = sda_f;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ADDR_ACK: if (scl_fall) begin
        sched     = 1'b1;
        sched_val = 1'b1;
      end else if (scl_rise) begin
        bit_cnt_d = 3'd0;
        if (rw_q) begin
          tx_req_d = 1'b1;
          state_d  = READ;
        end else begin
          state_d  = WRITE;
        end
      end
      WRITE: if (scl_fall) begin
        sched = 1'b1;
      end else if (scl_rise) begin
        shift_d   = {shift_q[BYTE_W-2:0], sda_f};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d  = {shift_q[BYTE_W-2:0], sda_f};
          rx_valid_d = 1'b1;
          rx_first_d = first_q;
          first_d    = 1'b0;
          state_d    = WR_ACK;
        end
      end
      WR_ACK: if (scl_fall) begin
        sched     = 1'b1;
        sched_val = 1'b1;
      end else if (scl_rise) begin
        bit_cnt_d = 3'd0;
        state_d   = WRITE;
      end
      // first fall of a byte presents bit 7 unshifted; later falls shift first
      READ: if (scl_fall) begin
        sched = 1'b1;
        if (bit_cnt_q == 3'd0) begin
          sched_val = ~shift_q[BYTE_W-1];
        end else begin
          shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
          sched_val = ~shift_q[BYTE_W-2];
        end
      end else if (scl_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          state_d   = RD_ACK;
        end
      end
      RD_ACK: if (scl_fall) begin
        sched = 1'b1;
      end else if (scl_rise) begin
        if (!sda_f) begin
          tx_req_d  = 1'b1;
          bit_cnt_d = 3'd0;
          state_d   = READ;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sched) begin
      hold_cnt_d  = 8'(HOLD_CYC - 1);
      hold_pend_d = 1'b1;
      hold_val_d  = sched_val;
    end

    if (start_det || stop_det) begin
      state_d     = start_det ? ADDR : IDLE;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      hold_pend_d = 1'b0;
      tx_load_d   = 1'b0;
      tx_req_d    = 1'b0;
      rx_valid_d  = 1'b0;
      rx_first_d  = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      hold_cnt_q  <= '0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      hold_pend_q <= 1'b0;
      hold_val_q  <= 1'b0;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      hold_cnt_q  <= hold_cnt_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      sda_oe_q    <= sda_oe_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      tx_req_q    <= tx_req_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      hold_pend_q <= hold_pend_d;
      hold_val_q  <= hold_val_d;
      scl_prev_q  <= scl_f;
      sda_prev_q  <= sda_f;
    end
  end

  assign bus.SdaOe   = sda_oe_q;
  assign bus.RxData  = rx_data_q;
  assign bus.RxValid = rx_valid_q;
  assign bus.RxFirst = rx_first_q;
  assign bus.TxReq   = tx_req_q;
  assign bus.Busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_responder.sv
// ============================================================================
// tb_i2c_responder: directed bus-master bench for i2c_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_responder;
  import i2c_responder_pkg::*;

  // SCL period is 2*HALF Clk; kept short so the whole run stays compact
  localparam int HALF = 100;
  localparam int Q    = HALF / 2;

  logic Clk = 1'b0;
  logic Reset;
  logic scl_m, sda_m;

  int checks = 0;
  int errors = 0;

  int         rx_cnt = 0;
  int         oe_cnt = 0;
  logic [8:0] rx_log [16];
  int         tx_served = 0;
  logic [7:0] tx_vals [32];

  i2c_responder_if bus ();

  assign bus.Scl   = scl_m;
  assign bus.SdaIn = sda_m & ~bus.SdaOe;

  i2c_responder #(.DEV_ADDR(7'h42), .FILT_LEN(4), .HOLD_CYC(30)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (bus.RxValid) begin
      rx_log[rx_cnt % 16] <= {bus.RxFirst, bus.RxData};
      rx_cnt <= rx_cnt + 1;
    end
    if (bus.SdaOe) oe_cnt <= oe_cnt + 1;
  end

  // read data is valid only in the one cycle the DUT is meant to latch it
  initial begin
    bus.TxData = 8'h00;
    forever begin
      @(negedge Clk);
      if (bus.TxReq) begin
        bus.TxData = ~tx_vals[tx_served % 32];
        @(negedge Clk);
        bus.TxData = tx_vals[tx_served % 32];
        @(negedge Clk);
        bus.TxData = ~tx_vals[tx_served % 32];
        tx_served = tx_served + 1;
      end
    end
  end

  initial begin
    #(900us);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic start_cond();
    if (scl_m == 1'b0) begin
      wait_clk(Q); sda_m = 1'b1;
      wait_clk(Q); scl_m = 1'b1;
    end
    wait_clk(HALF); sda_m = 1'b0;
    wait_clk(HALF); scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(HALF); sda_m = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_bit(input logic b, input bit glitch, output logic smp);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); smp = bus.SdaIn;
    if (glitch) begin
      wait_clk(10); scl_m = 1'b0;
      wait_clk(2);  scl_m = 1'b1;
      wait_clk(Q - 12);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], (glitch_bit == i), s);
    send_bit(1'b1, 1'b0, nack);
  endtask

  task automatic read_byte(input logic mnack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(mnack, 1'b0, s);
  endtask

  task automatic test_reset();
    checks++; if (bus.SdaOe !== 1'b0) begin errors++; $display("FAIL rst_sdaoe: got %b want 0", bus.SdaOe); end
    checks++; if (bus.RxData !== 8'h00) begin errors++; $display("FAIL rst_rxdata: got %h want 00", bus.RxData); end
    checks++; if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL rst_rxvalid: got %b want 0", bus.RxValid); end
    checks++; if (bus.RxFirst !== 1'b0) begin errors++; $display("FAIL rst_rxfirst: got %b want 0", bus.RxFirst); end
    checks++; if (bus.TxReq !== 1'b0) begin errors++; $display("FAIL rst_txreq: got %b want 0", bus.TxReq); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_write();
    logic n0, n1, n2;
    int r0 = rx_cnt;
    start_cond();
    write_byte(8'h84, -1, n0);
    write_byte(8'hA5, -1, n1);
    write_byte(8'h3C, -1, n2);
    checks++; if (n0 !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", n0); end
    checks++; if (n1 !== 1'b0) begin errors++; $display("FAIL wr_b1_ack: got %b want 0", n1); end
    checks++; if (n2 !== 1'b0) begin errors++; $display("FAIL wr_b2_ack: got %b want 0", n2); end
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL wr_busy_hi: got %b want 1", bus.Busy); end
    stop_cond();
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL wr_busy_lo: got %b want 0", bus.Busy); end
    checks++; if (rx_cnt - r0 !== 2) begin errors++; $display("FAIL wr_rx_count: got %0d want 2", rx_cnt - r0); end
    checks++; if (rx_log[r0 % 16] !== 9'h1A5) begin errors++; $display("FAIL wr_rx0: got %h want 1a5", rx_log[r0 % 16]); end
    checks++; if (rx_log[(r0 + 1) % 16] !== 9'h03C) begin errors++; $display("FAIL wr_rx1: got %h want 03c", rx_log[(r0 + 1) % 16]); end
  endtask

  task automatic test_read();
    logic n0;
    logic [7:0] d0, d1;
    int t0 = tx_served;
    tx_vals[t0 % 32]       = 8'h5A;
    tx_vals[(t0 + 1) % 32] = 8'hF0;
    start_cond();
    write_byte(8'h85, -1, n0);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checks++; if (n0 !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", n0); end
    checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL rd_byte0: got %h want 5a", d0); end
    checks++; if (d1 !== 8'hF0) begin errors++; $display("FAIL rd_byte1: got %h want f0", d1); end
    wait_clk(Q);
    checks++; if (bus.SdaOe !== 1'b0) begin errors++; $display("FAIL rd_nack_sdaoe: got %b want 0", bus.SdaOe); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rd_nack_busy: got %b want 0", bus.Busy); end
    stop_cond();
    wait_clk(HALF);
    checks++; if (tx_served - t0 !== 2) begin errors++; $display("FAIL rd_txreq_count: got %0d want 2", tx_served - t0); end
  endtask

  task automatic test_mismatch();
    logic n0, n1;
    int r0 = rx_cnt;
    int t0 = tx_served;
    int o0 = oe_cnt;
    start_cond();
    write_byte(8'h86, -1, n0);
    write_byte(8'h55, -1, n1);
    stop_cond();
    checks++; if (n0 !== 1'b1) begin errors++; $display("FAIL mm_addr_nack: got %b want 1", n0); end
    checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL mm_sdaoe_cycles: got %0d want 0", oe_cnt - o0); end
    checks++; if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL mm_rxvalid: got %0d want 0", rx_cnt - r0); end
    checks++; if (tx_served - t0 !== 0) begin errors++; $display("FAIL mm_txreq: got %0d want 0", tx_served - t0); end
  endtask

  task automatic test_repeated_start();
    logic n0, n1, n2;
    logic [7:0] d0;
    int r0 = rx_cnt;
    int t0 = tx_served;
    tx_vals[t0 % 32] = 8'h96;
    start_cond();
    write_byte(8'h84, -1, n0);
    write_byte(8'h11, -1, n1);
    start_cond();
    write_byte(8'h85, -1, n2);
    read_byte(1'b1, d0);
    stop_cond();
    checks++; if ({n0, n1, n2} !== 3'b000) begin errors++; $display("FAIL rs_acks: got %b want 000", {n0, n1, n2}); end
    checks++; if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL rs_rx_count: got %0d want 1", rx_cnt - r0); end
    checks++; if (rx_log[r0 % 16] !== 9'h111) begin errors++; $display("FAIL rs_rx0: got %h want 111", rx_log[r0 % 16]); end
    checks++; if (tx_served - t0 !== 1) begin errors++; $display("FAIL rs_txreq_count: got %0d want 1", tx_served - t0); end
    checks++; if (d0 !== 8'h96) begin errors++; $display("FAIL rs_read: got %h want 96", d0); end
  endtask

  task automatic test_glitch();
    logic n0, n1;
    int r0 = rx_cnt;
    start_cond();
    write_byte(8'h84, -1, n0);
    write_byte(8'hC3, 4, n1);
    stop_cond();
    checks++; if (n1 !== 1'b0) begin errors++; $display("FAIL gl_ack: got %b want 0", n1); end
    checks++; if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL gl_rx_count: got %0d want 1", rx_cnt - r0); end
    checks++; if (rx_log[r0 % 16] !== 9'h1C3) begin errors++; $display("FAIL gl_rx0: got %h want 1c3", rx_log[r0 % 16]); end
  endtask

  task automatic test_reset_mid();
    logic s, n0, n1;
    logic [7:0] a = 8'h84;
    int r0;
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(a[i], 1'b0, s);
    wait_clk(Q);
    checks++; if (bus.SdaOe !== 1'b1) begin errors++; $display("FAIL rm_ack_driven: got %b want 1", bus.SdaOe); end
    Reset = 1'b0;
    #1;
    checks++; if (bus.SdaOe !== 1'b0) begin errors++; $display("FAIL rm_async_release: got %b want 0", bus.SdaOe); end
    wait_clk(4);
    Reset = 1'b1;
    sda_m = 1'b1;
    wait_clk(20);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", bus.Busy); end
    stop_cond();
    r0 = rx_cnt;
    start_cond();
    write_byte(8'h84, -1, n0);
    write_byte(8'h77, -1, n1);
    stop_cond();
    checks++; if ({n0, n1} !== 2'b00) begin errors++; $display("FAIL rm_recover_acks: got %b want 00", {n0, n1}); end
    checks++; if (rx_log[r0 % 16] !== 9'h177 || rx_cnt - r0 !== 1) begin
      errors++; $display("FAIL rm_recover_rx: got %h count %0d want 177 count 1", rx_log[r0 % 16], rx_cnt - r0);
    end
  endtask

  task automatic test_general_call();
    logic n0, n1;
    int r0 = rx_cnt;
    start_cond();
    write_byte(8'h00, -1, n0);
    write_byte(8'h06, -1, n1);
    stop_cond();
`ifdef GENERAL_CALL_EN
    checks++; if ({n0, n1} !== 2'b00) begin errors++; $display("FAIL gc_acks: got %b want 00", {n0, n1}); end
    checks++; if (rx_log[r0 % 16] !== 9'h106 || rx_cnt - r0 !== 1) begin
      errors++; $display("FAIL gc_rx: got %h count %0d want 106 count 1", rx_log[r0 % 16], rx_cnt - r0);
    end
`else
    checks++; if (n0 !== 1'b1) begin errors++; $display("FAIL gc_nack: got %b want 1", n0); end
    checks++; if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL gc_no_rx: got %0d want 0", rx_cnt - r0); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tx_vals[i] = 8'hEE;
    Reset = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(5);
    test_reset();
    Reset = 1'b1;
    wait_clk(20);
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_glitch();
    test_reset_mid();
    test_general_call();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
